// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/PC control stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC  = '0;
  localparam logic [31:0] DEF_HALT_WORD = '1;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Program counter and fetch control: run/step, stall, redirect, halt-word
// detection and out-of-range address trapping ahead of instruction memory.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned             bitsDir   = 32,
  parameter logic [bitsDir-1:0]      RESET_PC  = DEF_RESET_PC,
  parameter int unsigned             ADDR_STEP = 1,
  parameter int unsigned             MEM_DEPTH = 128,
  parameter logic [bitsDir-1:0]      HALT_WORD = DEF_HALT_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [bitsDir-1:0] i_redirect_pc,
  input  logic [bitsDir-1:0] i_instruction,
  output logic [bitsDir-1:0] Addr,
  output logic [bitsDir-1:0] o_pc_plus,
  output logic               o_fetch_valid,
  output logic               o_flush,
  output logic               o_halted,
  output logic               o_addr_err,
  output logic [bitsDir-1:0] o_fetch_count
);

  localparam logic [bitsDir-1:0] PC_INC  = bitsDir'(ADDR_STEP);
  // One extra bit so a MEM_DEPTH of 2^bitsDir still compares correctly.
  localparam logic [bitsDir:0]   MEM_LIM = (bitsDir+1)'(MEM_DEPTH);

  fetch_state_t state;
  fetch_state_t mode_state;
  logic         active;
  logic         fetch_valid;
  logic         halt_hit;
  logic         range_err;

  // Fetch qualification and trap detection for the current PC.
  always_comb begin
    fetch_valid = 1'b0;
    active      = 1'b0;
    case (state)
      RUN:  begin fetch_valid = 1'b1;               active = 1'b1; end
      STEP: begin fetch_valid = i_step & ~i_stall;  active = 1'b1; end
      default: begin fetch_valid = 1'b0;            active = 1'b0; end
    endcase
    mode_state    = i_step_mode ? STEP : RUN;
    halt_hit      = fetch_valid & (i_instruction == HALT_WORD);
    range_err     = fetch_valid & ({1'b0, Addr} >= MEM_LIM);
    o_fetch_valid = fetch_valid & ~i_redirect;
    o_flush       = i_redirect & active;
    o_pc_plus     = Addr + PC_INC;
  end

  // Control FSM with next-PC priority: redirect > range error > halt > stall > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      Addr          <= RESET_PC;
      o_fetch_count <= '0;
      o_addr_err    <= 1'b0;
      o_halted      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (i_start) begin
            state         <= mode_state;
            Addr          <= RESET_PC;
            o_fetch_count <= '0;
            o_addr_err    <= 1'b0;
            o_halted      <= 1'b0;
          end
        end
        default: begin
          if (i_redirect) begin
            Addr  <= i_redirect_pc;
            state <= mode_state;
          end else if (range_err) begin
            state      <= HALTED;
            o_halted   <= 1'b1;
            o_addr_err <= 1'b1;
          end else if (halt_hit) begin
            // The halt word itself is handed downstream, so it is counted.
            state         <= HALTED;
            o_halted      <= 1'b1;
            o_fetch_count <= o_fetch_count + 1'b1;
          end else begin
            state <= mode_state;
            if (fetch_valid && !i_stall) begin
              Addr          <= Addr + PC_INC;
              o_fetch_count <= o_fetch_count + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a small word-indexed instruction memory.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_step_mode;
  logic        i_step;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] i_instruction;
  logic [31:0] Addr;
  logic [31:0] o_pc_plus;
  logic        o_fetch_valid;
  logic        o_flush;
  logic        o_halted;
  logic        o_addr_err;
  logic [31:0] o_fetch_count;

  logic [31:0] mem [0:31];
  int          total;
  int          bad;

  fetch_pc_ctrl #(
    .bitsDir   (32),
    .RESET_PC  (32'd0),
    .ADDR_STEP (1),
    .MEM_DEPTH (8),
    .HALT_WORD (HALT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_step_mode   (i_step_mode),
    .i_step        (i_step),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_instruction (i_instruction),
    .Addr          (Addr),
    .o_pc_plus     (o_pc_plus),
    .o_fetch_valid (o_fetch_valid),
    .o_flush       (o_flush),
    .o_halted      (o_halted),
    .o_addr_err    (o_addr_err),
    .o_fetch_count (o_fetch_count)
  );

  assign i_instruction = (Addr < 32'd32) ? mem[Addr[4:0]] : NOP;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) mem[i] = NOP;
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = HALT;
    rst_n = 1'b0; i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;

    #1;
    check("rst_addr",   Addr, 32'd0);
    check("rst_count",  o_fetch_count, 32'd0);
    check("rst_halted", {31'd0, o_halted}, 32'd0);
    check("rst_err",    {31'd0, o_addr_err}, 32'd0);
    check("rst_valid",  {31'd0, o_fetch_valid}, 32'd0);
    check("rst_flush",  {31'd0, o_flush}, 32'd0);
    check("rst_pcplus", o_pc_plus, 32'd1);

    // Free run into a halt word at address 3
    nclk(); rst_n = 1'b1;
    nclk(); i_start = 1'b1;
    nclk(); i_start = 1'b0;
    for (int a = 0; a < 4; a++) begin
      check("run_addr",  Addr, 32'(a));
      check("run_valid", {31'd0, o_fetch_valid}, 32'd1);
      check("run_nohalt", {31'd0, o_halted}, 32'd0);
      nclk();
    end
    check("halt_flag",  {31'd0, o_halted}, 32'd1);
    check("halt_addr",  Addr, 32'd3);
    check("halt_count", o_fetch_count, 32'd4);
    nclk();
    check("halt_hold",  Addr, 32'd3);

    // Restart from HALTED, then stall at address 5
    mem[3] = NOP;
    i_start = 1'b1;
    nclk(); i_start = 1'b0;
    check("restart_addr",  Addr, 32'd0);
    check("restart_count", o_fetch_count, 32'd0);
    check("restart_halt",  {31'd0, o_halted}, 32'd0);
    repeat (5) nclk();
    check("pre_stall_addr", Addr, 32'd5);
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nclk();
      check("stall_addr",  Addr, 32'd5);
      check("stall_count", o_fetch_count, 32'd5);
    end
    i_stall = 1'b0;
    nclk();
    check("post_stall_addr",  Addr, 32'd6);
    check("post_stall_count", o_fetch_count, 32'd6);

    // Redirect beats stall and halt word; target 20 is out of range
    mem[6] = HALT;
    i_stall = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'd20;
    #1;
    check("redir_flush", {31'd0, o_flush}, 32'd1);
    check("redir_valid", {31'd0, o_fetch_valid}, 32'd0);
    nclk();
    i_stall = 1'b0; i_redirect = 1'b0; mem[6] = NOP;
    check("redir_addr",   Addr, 32'd20);
    check("redir_nohalt", {31'd0, o_halted}, 32'd0);
    check("redir_count",  o_fetch_count, 32'd6);
    nclk();
    check("oob_halt",  {31'd0, o_halted}, 32'd1);
    check("oob_err",   {31'd0, o_addr_err}, 32'd1);
    check("oob_addr",  Addr, 32'd20);
    check("oob_count", o_fetch_count, 32'd6);

    // Redirect is ignored while halted
    i_redirect = 1'b1; i_redirect_pc = 32'd2;
    #1;
    check("halted_flush", {31'd0, o_flush}, 32'd0);
    nclk(); i_redirect = 1'b0;
    check("halted_redir_addr", Addr, 32'd20);

    // Single-step: three pulses, the middle one during a stall
    i_step_mode = 1'b1; i_start = 1'b1;
    nclk(); i_start = 1'b0;
    check("step_start_addr", Addr, 32'd0);
    check("step_err_clr",    {31'd0, o_addr_err}, 32'd0);
    check("step_idle_valid", {31'd0, o_fetch_valid}, 32'd0);
    i_step = 1'b1;
    nclk(); i_step = 1'b0;
    nclk();
    i_step = 1'b1; i_stall = 1'b1;
    #1;
    check("step_stall_valid", {31'd0, o_fetch_valid}, 32'd0);
    nclk(); i_step = 1'b0; i_stall = 1'b0;
    nclk();
    i_step = 1'b1;
    nclk(); i_step = 1'b0;
    check("step_addr",  Addr, 32'd2);
    check("step_count", o_fetch_count, 32'd2);
    nclk();
    i_step = 1'b1;
    repeat (3) nclk();
    i_step = 1'b0;
    check("step_hold_addr",  Addr, 32'd5);
    check("step_hold_count", o_fetch_count, 32'd5);

    // Back to free run until the PC walks off the end of memory
    i_step_mode = 1'b0;
    for (int w = 0; w < 20 && !o_halted; w++) nclk();
    check("end_halt",  {31'd0, o_halted}, 32'd1);
    check("end_addr",  Addr, 32'd8);
    check("end_err",   {31'd0, o_addr_err}, 32'd1);
    check("end_count", o_fetch_count, 32'd8);

    // Restart and abort with reset between clock edges at address 7
    i_start = 1'b1;
    nclk(); i_start = 1'b0;
    check("rs_addr",  Addr, 32'd0);
    check("rs_count", o_fetch_count, 32'd0);
    check("rs_err",   {31'd0, o_addr_err}, 32'd0);
    repeat (7) nclk();
    check("pre_rst_addr", Addr, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr",  Addr, 32'd0);
    check("async_rst_count", o_fetch_count, 32'd0);
    check("async_rst_valid", {31'd0, o_fetch_valid}, 32'd0);
    nclk();
    check("async_rst_hold", Addr, 32'd0);
    rst_n = 1'b1;
    nclk();
    check("idle_after_rst", Addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction memory read block.
- Drives `Addr` into the memory, which samples it on the negedge of the same cycle. The instruction therefore returns within that cycle, and the IF/ID register captures it on the next posedge.
- Handles run/single-step control from the debug unit, stalls, branch/jump redirects, halt-word detection and out-of-range address trapping.

Parameters:
- bitsDir, 32, PC/address/instruction width.
- RESET_PC, 0, PC value after reset and after restart.
- ADDR_STEP, 1, PC increment per fetch (memory is word-indexed).
- MEM_DEPTH, 128, number of valid instruction words; PC >= MEM_DEPTH is an address error.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  in  1  system clock, posedge for all state in this block.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse: leave IDLE/HALTED and begin fetching at RESET_PC.
- i_step_mode  in  1  1 = single-step mode, 0 = free run.
- i_step  in  1  pulse: one fetch while in STEP.
- i_stall  in  1  hazard stall from downstream; hold PC.
- i_redirect  in  1  branch/jump taken in a later stage.
- i_redirect_pc  in  bitsDir  redirect target.
- i_instruction  in  bitsDir  word returned by instruction memory for current Addr.
- Addr  out  bitsDir  current PC to instruction memory (registered).
- o_pc_plus  out  bitsDir  Addr + ADDR_STEP, combinational, for IF/ID.
- o_fetch_valid  out  1  current i_instruction is a real fetch for IF/ID.
- o_flush  out  1  IF/ID must load a bubble this cycle.
- o_halted  out  1  state == HALTED.
- o_addr_err  out  1  sticky: halted because of an out-of-range PC.
- o_fetch_count  out  bitsDir  accepted fetches since start; wraps modulo 2^bitsDir.

Behaviour:
- Reset (async, rst_n=0) values:
  - Addr=RESET_PC, state=IDLE, o_fetch_count=0, o_addr_err=0.
  - Combinational outputs take their IDLE values.
- States and fetch_valid:
  - IDLE: fetch_valid=0.
  - RUN: fetch_valid=1.
  - STEP: fetch_valid = i_step & ~i_stall.
  - HALTED: fetch_valid=0.
  - o_fetch_valid = fetch_valid & ~i_redirect.
- halt_hit = fetch_valid & (i_instruction == HALT_WORD).
- range_err = fetch_valid & (Addr >= MEM_DEPTH).
- Priority at each posedge, RUN/STEP only:
  1. i_redirect: Addr <= i_redirect_pc. This wins over stall, halt_hit and range_err, since those are on the wrong path. o_flush=1 that cycle; no count.
  2. range_err: go to HALTED, set o_addr_err, Addr held.
  3. halt_hit: go to HALTED, Addr held at the halt word address. The halt word is presented with o_fetch_valid=1 and counted, so downstream drains it.
  4. i_stall: Addr and count held.
  5. fetch_valid: Addr <= Addr + ADDR_STEP, truncated to bitsDir, and o_fetch_count increments.
- Transitions:
  - IDLE --i_start--> RUN if i_step_mode=0, else STEP.
  - RUN --i_step_mode=1--> STEP, taking effect next cycle; the current cycle still fetches.
  - STEP --i_step_mode=0--> RUN.
  - RUN/STEP --halt_hit or range_err (no redirect)--> HALTED.
  - HALTED --i_start--> RUN/STEP per i_step_mode. This sets Addr=RESET_PC, count=0, o_addr_err=0.
- i_start while in RUN/STEP is ignored.
- i_redirect and i_step in IDLE/HALTED are ignored.
- In STEP:
  - Each i_step pulse without stall yields exactly one fetch.
  - An i_step coinciding with i_stall is dropped, and the debug unit re-issues it.
  - Holding i_step high for N cycles yields N fetches.
- o_flush = i_redirect & (state is RUN or STEP); otherwise 0.
- Latency:
  - Addr changes at posedge.
  - The instruction is valid after that cycle's negedge.
  - The consumer samples it at the following posedge.
- rst_n asserted mid-run aborts immediately to reset values. Nothing is flushed explicitly; the IF/ID register resets itself.

Decomposition:
- Shared package fetch_pkg:
  - State enum: IDLE, RUN, STEP, HALTED.
  - Default HALT_WORD and RESET_PC constants.
- No sub-module needed. The next-PC priority mux and the FSM fit in one module.

Test Plan:
- Reset, then i_start with i_step_mode=0 and memory words 1,2,3 at 0..2, HALT_WORD at 3:
  - Addr goes 0,1,2,3 on consecutive cycles.
  - o_halted=1 after Addr=3.
  - o_fetch_count=4, and Addr stays at 3.
- i_stall high for 3 cycles at Addr=5 -> Addr holds at 5 and o_fetch_count frozen for 3 cycles, then Addr=6.
- i_redirect=1 with i_redirect_pc=20 while i_stall=1 and i_instruction=HALT_WORD:
  - o_flush=1 and o_fetch_valid=0.
  - Next Addr=20, not halted, count unchanged.
- i_step_mode=1, three isolated i_step pulses, one of them during i_stall -> Addr advances by exactly 2 and o_fetch_count=2.
- MEM_DEPTH=8, free run over non-halt words -> halts with Addr=8, o_addr_err=1 and o_fetch_count=8.
- In HALTED, pulse i_start -> Addr=0, o_fetch_count=0, o_addr_err=0, RUN resumes.
- rst_n low mid-run at Addr=7 -> Addr=0 and state IDLE immediately, without waiting for a clock edge.
